// File: rtl/riscv_test_monitor_pkg.sv
// Shared types and constants for the riscv_soc self-test monitor.
// The state encoding is fixed here so debug tools can decode the state register.
package riscv_test_monitor_pkg;

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StSettle  = 3'd1,
        StPass    = 3'd2,
        StFail    = 3'd3,
        StTimeout = 3'd4
    } state_e;

    // Register value that signals done, and also the value that means pass.
    localparam int unsigned DoneVal = 1;

    function automatic logic is_terminal(input state_e s);
        return (s == StPass) || (s == StFail) || (s == StTimeout);
    endfunction

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Snoop, status and trace signals between the core side and the self-test monitor.
// master drives the snooped core events and the trace pop; slave is the monitor.
interface riscv_test_monitor_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
);
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              jump_valid;
    logic [XLEN-1:0]   jump_src;
    logic [XLEN-1:0]   jump_dst;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [XLEN-1:0]   fail_testnum;
    logic [CNT_W-1:0]  cycle_count;
    logic              trace_rd;
    logic              trace_valid;
    logic [XLEN-1:0]   trace_src_o;
    logic [XLEN-1:0]   trace_dst_o;
    logic              trace_ovf;

    modport master (
        output rf_we, rf_waddr, rf_wdata, jump_valid, jump_src, jump_dst, trace_rd,
        input  done, pass, fail, timeout, fail_testnum, cycle_count,
        input  trace_valid, trace_src_o, trace_dst_o, trace_ovf
    );

    modport slave (
        input  rf_we, rf_waddr, rf_wdata, jump_valid, jump_src, jump_dst, trace_rd,
        output done, pass, fail, timeout, fail_testnum, cycle_count,
        output trace_valid, trace_src_o, trace_dst_o, trace_ovf
    );

endinterface

// File: rtl/riscv_test_monitor_trace_fifo.sv
// Show-ahead jump-trace FIFO with a sticky overflow flag.
// When full, a push either drops the new entry or replaces the oldest one (OVWR).
module trace_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 16,
    parameter bit          OVWR  = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         ovf
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         empty, full, pop_eff, wr_en;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop_eff  = pop && !empty;
        wr_en    = push && (!full || pop_eff || OVWR) && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        end
        // Overwrite mode retires the oldest entry to make room, unless a pop already did.
        if (pop_eff || (push && full && OVWR)) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end
        if (push && full && !pop_eff) begin
            ovf_d = 1'b1;
        end
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign valid = !empty;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign ovf   = ovf_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// Self-test monitor: snoops register writes to detect done/pass, enforces a cycle
// timeout and keeps a trace of taken jumps for post-mortem debug on hardware.
module riscv_test_monitor
    import riscv_test_monitor_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned DONE_REG       = 26,
    parameter int unsigned PASS_REG       = 27,
    parameter int unsigned TNUM_REG       = 3,
    parameter int unsigned SETTLE_CYCLES  = 6,
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TRACE_DEPTH    = 16,
    parameter bit          TRACE_OVWR     = 1'b0
) (
    input logic           clk,
    input logic           rst,
    input logic           clear,
    riscv_test_monitor_if.slave bus
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [XLEN-1:0]  pass_sh_q, pass_sh_d;
    logic [XLEN-1:0]  tnum_sh_q, tnum_sh_d;
    logic [XLEN-1:0]  fail_tnum_q, fail_tnum_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;
    logic             running, done_hit, trace_push;
    logic [2*XLEN-1:0] trace_dout;

    always_comb begin
        running  = (state_q == StRun) || (state_q == StSettle);
        done_hit = bus.rf_we && (bus.rf_waddr == REG_AW'(DONE_REG))
                   && (bus.rf_wdata == XLEN'(DoneVal)) && (DONE_REG != 0);

        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        settle_cnt_d = settle_cnt_q;
        pass_sh_d    = pass_sh_q;
        tnum_sh_d    = tnum_sh_q;
        fail_tnum_d  = fail_tnum_q;

        if (running) begin
            cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
            if (bus.rf_we && (bus.rf_waddr != '0)) begin
                if (bus.rf_waddr == REG_AW'(PASS_REG)) pass_sh_d = bus.rf_wdata;
                if (bus.rf_waddr == REG_AW'(TNUM_REG)) tnum_sh_d = bus.rf_wdata;
            end
        end

        case (state_q)
            StRun: begin
                if (done_hit) begin
                    state_d      = StSettle;
                    settle_cnt_d = '0;
                end else if (cycle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = StTimeout;
                    fail_tnum_d = tnum_sh_d;
                end
            end
            StSettle: begin
                settle_cnt_d = settle_cnt_q + SW'(1);
                // Decide on the shadow's next value so a pass write in this cycle still counts.
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d     = (pass_sh_d == XLEN'(DoneVal)) ? StPass : StFail;
                    fail_tnum_d = tnum_sh_d;
                end
            end
            default: ;
        endcase

        if (clear) begin
            state_d      = StRun;
            cycle_cnt_d  = '0;
            settle_cnt_d = '0;
            pass_sh_d    = '0;
            tnum_sh_d    = '0;
            fail_tnum_d  = '0;
        end

        done_d    = is_terminal(state_d);
        pass_d    = (state_d == StPass);
        fail_d    = (state_d == StFail);
        timeout_d = (state_d == StTimeout);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            cycle_cnt_q  <= '0;
            settle_cnt_q <= '0;
            pass_sh_q    <= '0;
            tnum_sh_q    <= '0;
            fail_tnum_q  <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            pass_sh_q    <= pass_sh_d;
            tnum_sh_q    <= tnum_sh_d;
            fail_tnum_q  <= fail_tnum_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
        end
    end

    assign trace_push = bus.jump_valid && running;

    trace_fifo #(
        .W     (2 * XLEN),
        .DEPTH (TRACE_DEPTH),
        .OVWR  (TRACE_OVWR)
    ) u_trace_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (trace_push),
        .din   ({bus.jump_src, bus.jump_dst}),
        .pop   (bus.trace_rd),
        .valid (bus.trace_valid),
        .dout  (trace_dout),
        .ovf   (bus.trace_ovf)
    );

    assign bus.trace_src_o  = trace_dout[2*XLEN-1:XLEN];
    assign bus.trace_dst_o  = trace_dout[XLEN-1:0];
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.fail         = fail_q;
    assign bus.timeout      = timeout_q;
    assign bus.fail_testnum = fail_tnum_q;
    assign bus.cycle_count  = cycle_cnt_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: two instances (drop vs overwrite trace mode) share stimulus;
// expected outcomes and trace entries are queued at stimulus time and popped when observed.
module tb_riscv_test_monitor;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
    } tr_t;

    logic clk;
    logic rst;
    logic clear;
    int   checks;
    int   failures;
    int   cyc;

    // {done, pass, fail, timeout, fail_testnum, cycle_count}
    logic [67:0] exp_q[$];
    tr_t         q0[$];
    tr_t         q1[$];
    bit          ovf0_exp, ovf1_exp;

    riscv_test_monitor_if #(.XLEN(32), .REG_AW(5), .CNT_W(32)) if0 ();
    riscv_test_monitor_if #(.XLEN(32), .REG_AW(5), .CNT_W(32)) if1 ();

    assign if1.rf_we      = if0.rf_we;
    assign if1.rf_waddr   = if0.rf_waddr;
    assign if1.rf_wdata   = if0.rf_wdata;
    assign if1.jump_valid = if0.jump_valid;
    assign if1.jump_src   = if0.jump_src;
    assign if1.jump_dst   = if0.jump_dst;
    assign if1.trace_rd   = if0.trace_rd;

    riscv_test_monitor #(.TIMEOUT_CYCLES(100), .TRACE_DEPTH(4), .TRACE_OVWR(1'b0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (if0)
    );

    riscv_test_monitor #(.TIMEOUT_CYCLES(100), .TRACE_DEPTH(4), .TRACE_OVWR(1'b1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic tr_t ent(input int i);
        tr_t r;
        r.src = 32'h0000_1000 + 32'(4 * i);
        r.dst = 32'h8000_0000 + 32'(i);
        return r;
    endfunction

    function automatic logic [67:0] obs0();
        return {if0.done, if0.pass, if0.fail, if0.timeout, if0.fail_testnum, if0.cycle_count};
    endfunction

    function automatic logic [67:0] obs1();
        return {if1.done, if1.pass, if1.fail, if1.timeout, if1.fail_testnum, if1.cycle_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        if0.rf_we      = 1'b0;
        if0.rf_waddr   = '0;
        if0.rf_wdata   = '0;
        if0.jump_valid = 1'b0;
        if0.jump_src   = '0;
        if0.jump_dst   = '0;
        if0.trace_rd   = 1'b0;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        ovf0_exp = 1'b0;
        ovf1_exp = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cyc   = 0;
        model_reset();
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        if0.rf_we    = 1'b1;
        if0.rf_waddr = a;
        if0.rf_wdata = d;
        tick();
        if0.rf_we    = 1'b0;
    endtask

    task automatic model_step(input bit push, input bit pop, input tr_t e);
        if (pop && q0.size() > 0) void'(q0.pop_front());
        if (push) begin
            if (q0.size() < 4) q0.push_back(e);
            else ovf0_exp = 1'b1;
        end
        if (pop && q1.size() > 0) void'(q1.pop_front());
        if (push) begin
            if (q1.size() >= 4) begin
                void'(q1.pop_front());
                ovf1_exp = 1'b1;
            end
            q1.push_back(e);
        end
    endtask

    task automatic jump_cycle(input tr_t e, input bit pop);
        if0.jump_valid = 1'b1;
        if0.jump_src   = e.src;
        if0.jump_dst   = e.dst;
        if0.trace_rd   = pop;
        model_step(1'b1, pop, e);
        tick();
        if0.jump_valid = 1'b0;
        if0.trace_rd   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (!if0.done && n < budget) begin
            tick();
            n++;
        end
        ok = if0.done;
    endtask

    task automatic drain_trace(input string tag);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (if0.trace_valid !== (q0.size() > 0) || if1.trace_valid !== (q1.size() > 0)) begin
                failures++;
                $display("FAIL %s_valid got=%0b/%0b exp=%0b/%0b", tag, if0.trace_valid,
                         if1.trace_valid, q0.size() > 0, q1.size() > 0);
            end
            if (q0.size() > 0) begin
                checks++;
                if ({if0.trace_src_o, if0.trace_dst_o} !== q0[0]) begin
                    failures++;
                    $display("FAIL %s_head0 got=%h exp=%h", tag,
                             {if0.trace_src_o, if0.trace_dst_o}, q0[0]);
                end
            end
            if (q1.size() > 0) begin
                checks++;
                if ({if1.trace_src_o, if1.trace_dst_o} !== q1[0]) begin
                    failures++;
                    $display("FAIL %s_head1 got=%h exp=%h", tag,
                             {if1.trace_src_o, if1.trace_dst_o}, q1[0]);
                end
            end
            if (q0.size() == 0 && q1.size() == 0) break;
            if0.trace_rd = 1'b1;
            model_step(1'b0, 1'b1, '0);
            tick();
            if0.trace_rd = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        clear = 1'b0;
        idle_inputs();
        model_reset();
        tick();
        tick();
        checks++;
        if (obs0() !== '0 || obs1() !== '0 || if0.trace_valid !== 1'b0 || if0.trace_ovf !== 1'b0
            || {if0.trace_src_o, if0.trace_dst_o} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h/%h exp=0", obs0(), obs1());
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_pass_basic();
        bit ok;
        logic [67:0] e;
        do_clear();
        rf_write(5'd27, 32'd1);
        while (cyc < 10) tick();
        rf_write(5'd26, 32'd1);
        exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd17});
        while (cyc < 16) tick();
        checks++;
        if (if0.done !== 1'b0) begin
            failures++;
            $display("FAIL pass_early got done=%0b exp=0 at cycle 16", if0.done);
        end
        wait_done(5, ok);
        checks++;
        if (!ok || cyc != 17) begin
            failures++;
            $display("FAIL pass_latency got cycle=%0d done=%0b exp cycle=17 done=1", cyc, ok);
        end
        e = exp_q.pop_front();
        checks++;
        if (obs0() !== e || obs1() !== e) begin
            failures++;
            $display("FAIL pass_outcome got=%h/%h exp=%h", obs0(), obs1(), e);
        end
        tick();
        tick();
        checks++;
        if (obs0() !== e) begin
            failures++;
            $display("FAIL pass_frozen got=%h exp=%h", obs0(), e);
        end
    endtask

    task automatic test_fail_and_late_pass();
        bit ok;
        logic [67:0] e;
        do_clear();
        rf_write(5'd3, 32'd5);
        rf_write(5'd27, 32'd0);
        rf_write(5'd26, 32'd1);
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 32'd9});
        wait_done(20, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || obs0() !== e || obs1() !== e) begin
            failures++;
            $display("FAIL fail_outcome got=%h/%h exp=%h", obs0(), obs1(), e);
        end
        do_clear();
        rf_write(5'd3, 32'd7);
        rf_write(5'd27, 32'd0);
        rf_write(5'd26, 32'd1);
        exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 32'd7, 32'd9});
        tick();
        tick();
        rf_write(5'd27, 32'd1);
        wait_done(20, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || obs0() !== e) begin
            failures++;
            $display("FAIL late_pass_outcome got=%h exp=%h", obs0(), e);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [67:0] e;
        do_clear();
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd100});
        while (cyc < 99) tick();
        checks++;
        if (if0.done !== 1'b0 || if0.timeout !== 1'b0 || if0.cycle_count !== 32'd99) begin
            failures++;
            $display("FAIL timeout_early got done=%0b cnt=%0d exp done=0 cnt=99", if0.done,
                     if0.cycle_count);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs0() !== e || obs1() !== e) begin
            failures++;
            $display("FAIL timeout_outcome got=%h/%h exp=%h", obs0(), obs1(), e);
        end
        do_clear();
        while (cyc < 99) tick();
        rf_write(5'd26, 32'd1);
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd106});
        checks++;
        if (if0.done !== 1'b0 || if0.timeout !== 1'b0) begin
            failures++;
            $display("FAIL done_beats_timeout got done=%0b timeout=%0b exp 0 0", if0.done,
                     if0.timeout);
        end
        wait_done(20, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || obs0() !== e) begin
            failures++;
            $display("FAIL settle_after_99 got=%h exp=%h", obs0(), e);
        end
    endtask

    task automatic test_trace_overflow();
        do_clear();
        for (int i = 1; i <= 6; i++) jump_cycle(ent(i), 1'b0);
        checks++;
        if (if0.trace_ovf !== ovf0_exp || if1.trace_ovf !== ovf1_exp) begin
            failures++;
            $display("FAIL trace_ovf got=%0b/%0b exp=%0b/%0b", if0.trace_ovf, if1.trace_ovf,
                     ovf0_exp, ovf1_exp);
        end
        drain_trace("ovf_drain");
    endtask

    task automatic test_back_to_back();
        do_clear();
        for (int i = 1; i <= 4; i++) jump_cycle(ent(i), 1'b0);
        jump_cycle(ent(5), 1'b1);
        checks++;
        if (if0.trace_ovf !== 1'b0 || if1.trace_ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ovf got=%0b/%0b exp=0/0", if0.trace_ovf, if1.trace_ovf);
        end
        drain_trace("b2b_drain");
    endtask

    task automatic test_reset_and_clear();
        bit ok;
        logic [67:0] e;
        do_clear();
        jump_cycle(ent(9), 1'b0);
        rf_write(5'd27, 32'd1);
        rf_write(5'd26, 32'd1);
        tick();
        checks++;
        if (if0.trace_valid !== 1'b1 || if0.cycle_count !== 32'd4) begin
            failures++;
            $display("FAIL pre_rst got valid=%0b cnt=%0d exp valid=1 cnt=4", if0.trace_valid,
                     if0.cycle_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs0() !== '0 || if0.trace_valid !== 1'b0 || if1.trace_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_rst got=%h valid=%0b exp=0", obs0(), if0.trace_valid);
        end
        #1;
        rst = 1'b0;
        cyc = 0;
        model_reset();
        rf_write(5'd27, 32'd1);
        rf_write(5'd26, 32'd1);
        exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd8});
        wait_done(20, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || obs0() !== e) begin
            failures++;
            $display("FAIL rerun_pass got=%h exp=%h", obs0(), e);
        end
        do_clear();
        checks++;
        if (obs0() !== '0 || obs1() !== '0) begin
            failures++;
            $display("FAIL clear_in_pass got=%h/%h exp=0", obs0(), obs1());
        end
        tick();
        tick();
        tick();
        checks++;
        if (if0.cycle_count !== 32'd3 || if0.done !== 1'b0) begin
            failures++;
            $display("FAIL rerun_count got=%0d exp=3", if0.cycle_count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        test_reset();
        test_pass_basic();
        test_fail_and_late_pass();
        test_timeout();
        test_trace_overflow();
        test_back_to_back();
        test_reset_and_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
